regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file for the RISC-V pipeline. Generalises the current 2-read/1-write file.
- Adds configurable width and depth, and a synchronous active-low clear.
- Adds write-to-read bypass in the same cycle, and an optional hardwired zero register.
- Adds a per-register pending-write scoreboard, which decode uses to raise stall requests.

Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, >= 2)
- AW, 5, register index width, equal to log2(NREG)
- ZERO_R0, 1, 1 = register 0 reads as 0, ignores writes and is never marked busy
- BYPASS, 1, 1 = a read of the register being written this cycle returns wr_data

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- rs1_addr  in  AW  read port 1 index
- rs2_addr  in  AW  read port 2 index
- rs1_data  out  XLEN  read port 1 data (combinational)
- rs2_data  out  XLEN  read port 2 data (combinational)
- rs1_busy  out  1  scoreboard bit of rs1_addr
- rs2_busy  out  1  scoreboard bit of rs2_addr
- stall  out  1  rs1_busy OR rs2_busy, qualified by rs1_used / rs2_used
- rs1_used  in  1  decoded instruction reads rs1
- rs2_used  in  1  decoded instruction reads rs2
- iss_valid  in  1  instruction issued that will write iss_rd
- iss_rd  in  AW  destination index of the issued instruction
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback index
- wr_data  in  XLEN  writeback data
- wr_last  in  1  this writeback retires the youngest pending write to wr_addr (clears busy)

Behaviour:
- Reset: on a rising clk with rst_n=0, all registers are cleared to 0 and all busy bits are cleared.
  - While rst_n=0, wr_en and iss_valid are ignored.
  - Outputs are combinational, so after reset rs*_data=0, rs*_busy=0 and stall=0 for any address.
- Write: on a rising clk with rst_n=1, wr_en=1 and (wr_addr!=0 or ZERO_R0=0), reg[wr_addr] <= wr_data.
  - Latency is 1 cycle to the storage array.
- Read: rs1_data = reg[rs1_addr] (rs2 identical), with two overrides:
  - ZERO_R0=1 and rs1_addr=0: output is 0.
  - BYPASS=1, wr_en=1, wr_addr=rs1_addr and the address is not the zero register: output is wr_data in the same cycle (zero-latency forwarding).
  - BYPASS=0: the new value is visible the cycle after the write.
- Scoreboard: busy[NREG-1:0] is updated each rising clk with rst_n=1.
  - Set: iss_valid=1 and iss_rd is not the zero register sets busy[iss_rd].
  - Clear: wr_en=1 and wr_last=1 clears busy[wr_addr].
  - Same index set and cleared in one cycle: set wins, because the new issue is younger than the retiring write.
  - Different indices: both updates apply.
  - Set on an already-busy register: it stays 1. There is no counting; the pipeline guarantees in-order writeback and drives wr_last accordingly.
  - Clear on a non-busy register: no effect, no error.
- Busy outputs: rs1_busy = busy[rs1_addr], except it is forced to 0 when a clear of that index happens in the current cycle and BYPASS=1, because the data is being forwarded.
  - With BYPASS=0, rs1_busy stays 1 in that cycle and drops the cycle after.
  - The zero register always reports busy=0 when ZERO_R0=1.
- stall = (rs1_used & rs1_busy) | (rs2_used & rs2_busy). Purely combinational, no register.
- Writes to the zero register: data and busy are both discarded when ZERO_R0=1.
- Address width: addresses >= NREG are not possible when NREG = 2^AW. No wrap or extension logic is required.
- Reset mid-operation: pending busy bits are lost. The pipeline is flushed by the same reset, so this is correct.

Test Plan:
- Reset then read all addresses. Hold rst_n=0 one cycle, release, sweep rs1_addr/rs2_addr 0..31 -> every rs*_data=0, rs*_busy=0, stall=0.
- Write then read, with bypass. Cycle N: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rs1_addr=5 -> rs1_data=0xDEADBEEF in cycle N (BYPASS=1).
  - With BYPASS=0 the cycle N value is the old 0, and 0xDEADBEEF appears in N+1.
- Zero register. Write 0x12345678 to address 0, then iss_valid=1 with iss_rd=0 -> rs1_addr=0 reads 0 and rs1_busy=0 on all following cycles.
- Scoreboard stall.
  - iss_valid=1, iss_rd=7 -> next cycle rs2_addr=7 with rs2_used=1 gives stall=1.
  - wr_en=1, wr_last=1, wr_addr=7, wr_data=0xA5 -> same cycle stall=0 and rs2_data=0xA5.
  - Next cycle busy[7]=0.
- Simultaneous set and clear on one index. busy[3]=1; in one cycle drive iss_valid=1, iss_rd=3 and wr_en=1, wr_last=1, wr_addr=3, wr_data=0x9 -> reg[3]=0x9 and busy[3]=1 after the edge.
- Reset mid-flight. Set busy[10] and write reg[10]=0x55, then pulse rst_n=0 for one cycle -> reg[10]=0 and busy[10]=0.
  - A wr_en=1 driven during that reset cycle is ignored.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register file port bundle: two read ports with scoreboard status,
// an issue port that marks destinations busy, and a writeback port.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            stall;
  logic            rs1_used;
  logic            rs2_used;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_last;

  modport master (
    output rs1_addr, rs2_addr, rs1_used, rs2_used,
    output iss_valid, iss_rd,
    output wr_en, wr_addr, wr_data, wr_last,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall
  );

  modport slave (
    input  rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  iss_valid, iss_rd,
    input  wr_en, wr_addr, wr_data, wr_last,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, stall
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised 2R/1W integer register file with same-cycle bypass,
// optional hardwired zero register and a pending-write scoreboard.
module regfile_sb #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input logic        clk,
  input logic        rst_n,
  regfile_sb_if.slave rf
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic wr_act;
  logic wr_ok;
  logic clr_act;
  logic set_ok;
  logic z1, z2;
  logic f1, f2;
  logic c1, c2;

  // wr_en has no effect while reset is held, including on forwarding
  assign wr_act  = rf.wr_en & rst_n;
  assign wr_ok   = wr_act &
                   !(ZERO_R0 != 0 && rf.wr_addr == '0);
  assign clr_act = wr_act & rf.wr_last;
  assign set_ok  = rf.iss_valid &
                   !(ZERO_R0 != 0 && rf.iss_rd == '0);

  assign z1 = (ZERO_R0 != 0) && (rf.rs1_addr == '0);
  assign z2 = (ZERO_R0 != 0) && (rf.rs2_addr == '0);
  assign f1 = (BYPASS != 0) && wr_act && !z1 &&
              (rf.wr_addr == rf.rs1_addr);
  assign f2 = (BYPASS != 0) && wr_act && !z2 &&
              (rf.wr_addr == rf.rs2_addr);
  assign c1 = f1 && rf.wr_last;
  assign c2 = f2 && rf.wr_last;

  always_comb begin
    busy_nxt = busy;
    if (clr_act) busy_nxt[rf.wr_addr] = 1'b0;
    // a younger issue overrides a retiring write to the same index
    if (set_ok) busy_nxt[rf.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) regs[rf.wr_addr] <= rf.wr_data;
      busy <= busy_nxt;
    end
  end

  always_comb begin
    rf.rs1_data = regs[rf.rs1_addr];
    unique case (1'b1)
      z1:      rf.rs1_data = '0;
      f1:      rf.rs1_data = rf.wr_data;
      default: rf.rs1_data = regs[rf.rs1_addr];
    endcase
  end

  always_comb begin
    rf.rs2_data = regs[rf.rs2_addr];
    unique case (1'b1)
      z2:      rf.rs2_data = '0;
      f2:      rf.rs2_data = rf.wr_data;
      default: rf.rs2_data = regs[rf.rs2_addr];
    endcase
  end

  assign rf.rs1_busy = !z1 && !c1 && busy[rf.rs1_addr];
  assign rf.rs2_busy = !z2 && !c2 && busy[rf.rs2_addr];

  assign rf.stall = (rf.rs1_used & rf.rs1_busy) |
                    (rf.rs2_used & rf.rs2_busy);

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an
// array-based architectural model.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .AW(5)) rf ();

  regfile_sb #(
    .XLEN(32), .NREG(32), .AW(5),
    .ZERO_R0(1), .BYPASS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rf(rf)
  );

  logic [31:0] m_reg [32];
  bit          m_busy [32];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return 32'h0;
    if (rf.wr_en && int'(rf.wr_addr) == a) return rf.wr_data;
    return m_reg[a];
  endfunction

  function automatic bit m_bsy(input int a);
    if (a == 0) return 1'b0;
    if (rf.wr_en && rf.wr_last && int'(rf.wr_addr) == a)
      return 1'b0;
    return m_busy[a];
  endfunction

  task automatic idle();
    rf.rs1_addr  = '0;
    rf.rs2_addr  = '0;
    rf.rs1_used  = 1'b0;
    rf.rs2_used  = 1'b0;
    rf.iss_valid = 1'b0;
    rf.iss_rd    = '0;
    rf.wr_en     = 1'b0;
    rf.wr_addr   = '0;
    rf.wr_data   = '0;
    rf.wr_last   = 1'b0;
  endtask

  task automatic settle();
    bit b1, b2;
    #1;
    if (rst_n) begin
      b1 = m_bsy(int'(rf.rs1_addr));
      b2 = m_bsy(int'(rf.rs2_addr));
      chk("rs1_data", rf.rs1_data, m_read(int'(rf.rs1_addr)));
      chk("rs2_data", rf.rs2_data, m_read(int'(rf.rs2_addr)));
      chk("rs1_busy", 32'(rf.rs1_busy), 32'(b1));
      chk("rs2_busy", 32'(rf.rs2_busy), 32'(b2));
      chk("stall", 32'(rf.stall),
          32'((rf.rs1_used & b1) | (rf.rs2_used & b2)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (rf.wr_en && rf.wr_addr != 0)
        m_reg[rf.wr_addr] = rf.wr_data;
      if (rf.wr_en && rf.wr_last) m_busy[rf.wr_addr] = 1'b0;
      if (rf.iss_valid && rf.iss_rd != 0) m_busy[rf.iss_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'hx;
      m_busy[i] = 1'b1;
    end
    idle();
    @(negedge clk);

    // reset with stray write/issue that must be ignored
    rst_n = 1'b0;
    rf.wr_en = 1'b1; rf.wr_addr = 5'd4; rf.wr_data = 32'h1111;
    rf.iss_valid = 1'b1; rf.iss_rd = 5'd4;
    cyc();
    rst_n = 1'b1;
    idle();
    for (int a = 0; a < 32; a++) begin
      rf.rs1_addr = 5'(a);
      rf.rs2_addr = 5'(31 - a);
      rf.rs1_used = 1'b1;
      rf.rs2_used = 1'b1;
      settle();
      chk("rst_rs1", rf.rs1_data, 32'h0);
      chk("rst_stall", 32'(rf.stall), 32'h0);
      tick();
    end

    // write with same-cycle forward
    idle();
    rf.wr_en = 1'b1; rf.wr_addr = 5'd5; rf.wr_data = 32'hDEADBEEF;
    rf.rs1_addr = 5'd5;
    settle();
    chk("byp_rs1", rf.rs1_data, 32'hDEADBEEF);
    tick();
    idle();
    rf.rs2_addr = 5'd5;
    settle();
    chk("wr_hold", rf.rs2_data, 32'hDEADBEEF);
    tick();

    // zero register ignores data and busy
    idle();
    rf.wr_en = 1'b1; rf.wr_data = 32'h12345678;
    cyc();
    idle();
    rf.iss_valid = 1'b1;
    cyc();
    idle();
    rf.rs1_used = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("r0_data", rf.rs1_data, 32'h0);
      chk("r0_busy", 32'(rf.rs1_busy), 32'h0);
      tick();
    end

    // scoreboard stall and forwarded clear
    idle();
    rf.iss_valid = 1'b1; rf.iss_rd = 5'd7;
    cyc();
    idle();
    rf.rs2_addr = 5'd7; rf.rs2_used = 1'b1;
    settle();
    chk("sb_stall", 32'(rf.stall), 32'h1);
    tick();
    rf.wr_en = 1'b1; rf.wr_last = 1'b1;
    rf.wr_addr = 5'd7; rf.wr_data = 32'hA5;
    settle();
    chk("clr_stall", 32'(rf.stall), 32'h0);
    chk("clr_data", rf.rs2_data, 32'hA5);
    tick();
    idle();
    rf.rs2_addr = 5'd7; rf.rs2_used = 1'b1;
    settle();
    chk("clr_busy", 32'(rf.rs2_busy), 32'h0);
    tick();

    // same-index set and clear: set wins
    idle();
    rf.iss_valid = 1'b1; rf.iss_rd = 5'd3;
    cyc();
    rf.wr_en = 1'b1; rf.wr_last = 1'b1;
    rf.wr_addr = 5'd3; rf.wr_data = 32'h9;
    cyc();
    idle();
    rf.rs1_addr = 5'd3;
    settle();
    chk("sc_data", rf.rs1_data, 32'h9);
    chk("sc_busy", 32'(rf.rs1_busy), 32'h1);
    tick();

    // reset mid-flight
    idle();
    rf.iss_valid = 1'b1; rf.iss_rd = 5'd10;
    rf.wr_en = 1'b1; rf.wr_addr = 5'd10; rf.wr_data = 32'h55;
    cyc();
    rst_n = 1'b0;
    rf.iss_valid = 1'b0;
    rf.wr_data = 32'h77;
    cyc();
    rst_n = 1'b1;
    idle();
    rf.rs1_addr = 5'd10;
    settle();
    chk("mrst_data", rf.rs1_data, 32'h0);
    chk("mrst_busy", 32'(rf.rs1_busy), 32'h0);
    tick();

    // random traffic, addresses biased to collide
    for (int n = 0; n < 600; n++) begin
      rst_n        = ($urandom_range(0, 79) != 0);
      rf.rs1_addr  = 5'($urandom_range(0, 3) == 0 ?
                     $urandom_range(0, 31) : $urandom_range(0, 7));
      rf.rs2_addr  = 5'($urandom_range(0, 7));
      rf.rs1_used  = 1'($urandom);
      rf.rs2_used  = 1'($urandom);
      rf.iss_valid = 1'($urandom);
      rf.iss_rd    = 5'($urandom_range(0, 7));
      rf.wr_en     = 1'($urandom);
      rf.wr_addr   = 5'($urandom_range(0, 7));
      rf.wr_data   = $urandom;
      rf.wr_last   = 1'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
